// File: rtl/alu_decode_unit.sv
// alu_decode_unit: RV32I main-control decode, ALU-control decode and ALU,
// with every output registered (one-cycle latency from valid_i to valid_o).
//
// Ports:
//   clk_i          - clock
//   rst_ni         - synchronous active-low reset
//   valid_i        - qualifies instr_i / operands this cycle
//   instr_i        - RV32I instruction word
//   rs1_i          - ALU operand A
//   rs2_i          - register operand B
//   imm_i          - sign-extended immediate operand B
//   valid_o        - registered valid_i
//   result_o       - registered ALU result
//   zero_o         - registered (result == 0)
//   alu_ctrl_o     - registered ALU operation code
//   aluop_o        - registered main-control ALU class
//   branch_o, memread_o, memtoreg_o, memwrite_o, alusrc_o, regwrite_o
//                  - registered main-control signals
//   branch_taken_o - registered branch decision
//   illegal_o      - registered unsupported-opcode flag
module alu_decode_unit #(
    parameter int unsigned WORD = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [WORD-1:0] rs1_i,
    input  logic [WORD-1:0] rs2_i,
    input  logic [WORD-1:0] imm_i,
    output logic            valid_o,
    output logic [WORD-1:0] result_o,
    output logic            zero_o,
    output logic [3:0]      alu_ctrl_o,
    output logic [1:0]      aluop_o,
    output logic            branch_o,
    output logic            memread_o,
    output logic            memtoreg_o,
    output logic            memwrite_o,
    output logic            alusrc_o,
    output logic            regwrite_o,
    output logic            branch_taken_o,
    output logic            illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       b30;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign b30    = instr_i[30];

    // Fields the decoder never looks at (register indices, immediate bits).
    logic unused_instr;
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    // ---------------- main control ----------------
    logic       alusrc, memtoreg, regwrite, memread, memwrite, branch, illegal;
    logic [1:0] aluop;

    always_comb begin
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        illegal  = 1'b0;
        unique case (opcode)
            OP_R: begin
                regwrite = 1'b1;
                aluop    = 2'b10;
            end
            OP_I_ALU: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
                aluop    = 2'b11;
            end
            OP_LOAD: begin
                alusrc   = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                memread  = 1'b1;
            end
            OP_STORE: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            OP_BRANCH: begin
                branch = 1'b1;
                aluop  = 2'b01;
            end
            default: illegal = 1'b1;
        endcase
    end

    // ---------------- ALU control ----------------
    logic [3:0] alu_ctrl;

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (aluop)
            2'b00: alu_ctrl = ALU_ADD;
            // Branches compare via the ALU: SUB for eq/ne, SLT/SLTU for lt/ge.
            2'b01: begin
                unique case (funct3)
                    3'b100, 3'b101: alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl = ALU_SLTU;
                    default:        alu_ctrl = ALU_SUB;
                endcase
            end
            default: begin
                unique case (funct3)
                    // Immediate forms have no SUBI: b30 is part of the immediate.
                    3'b000:  alu_ctrl = (b30 && aluop == 2'b10) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = b30 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

    // ---------------- ALU ----------------
    logic [WORD-1:0] op_b;
    logic [WORD-1:0] alu_result;
    logic [4:0]      shamt;
    logic            zero;

    assign op_b  = alusrc ? imm_i : rs2_i;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = '0;
        unique case (alu_ctrl)
            ALU_AND:  alu_result = rs1_i & op_b;
            ALU_OR:   alu_result = rs1_i | op_b;
            ALU_ADD:  alu_result = rs1_i + op_b;
            ALU_XOR:  alu_result = rs1_i ^ op_b;
            ALU_SLL:  alu_result = rs1_i << shamt;
            ALU_SRL:  alu_result = rs1_i >> shamt;
            ALU_SUB:  alu_result = rs1_i - op_b;
            ALU_SRA:  alu_result = $unsigned($signed(rs1_i) >>> shamt);
            ALU_SLT:  alu_result = {{(WORD-1){1'b0}}, ($signed(rs1_i) < $signed(op_b))};
            ALU_SLTU: alu_result = {{(WORD-1){1'b0}}, (rs1_i < op_b)};
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // ---------------- branch decision ----------------
    logic branch_taken;

    always_comb begin
        branch_taken = 1'b0;
        if (branch) begin
            unique case (funct3)
                3'b000:         branch_taken = zero;
                3'b001:         branch_taken = !zero;
                3'b100, 3'b110: branch_taken = !zero;
                3'b101, 3'b111: branch_taken = zero;
                default:        branch_taken = 1'b0;
            endcase
        end
    end

    // ---------------- output registers ----------------
    logic            valid_q, zero_q, branch_q, memread_q, memtoreg_q, memwrite_q;
    logic            alusrc_q, regwrite_q, branch_taken_q, illegal_q;
    logic [WORD-1:0] result_q;
    logic [3:0]      alu_ctrl_q;
    logic [1:0]      aluop_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q        <= 1'b0;
            result_q       <= '0;
            zero_q         <= 1'b0;
            alu_ctrl_q     <= 4'b0000;
            aluop_q        <= 2'b00;
            branch_q       <= 1'b0;
            memread_q      <= 1'b0;
            memtoreg_q     <= 1'b0;
            memwrite_q     <= 1'b0;
            alusrc_q       <= 1'b0;
            regwrite_q     <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else if (valid_i) begin
            valid_q        <= 1'b1;
            result_q       <= alu_result;
            zero_q         <= zero;
            alu_ctrl_q     <= alu_ctrl;
            aluop_q        <= aluop;
            branch_q       <= branch;
            memread_q      <= memread;
            memtoreg_q     <= memtoreg;
            memwrite_q     <= memwrite;
            alusrc_q       <= alusrc;
            regwrite_q     <= regwrite;
            branch_taken_q <= branch_taken;
            illegal_q      <= illegal;
        end else begin
            // Bubble: side-effecting controls drop, datapath fields hold.
            valid_q        <= 1'b0;
            branch_q       <= 1'b0;
            memread_q      <= 1'b0;
            memwrite_q     <= 1'b0;
            regwrite_q     <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
        end
    end

    assign valid_o        = valid_q;
    assign result_o       = result_q;
    assign zero_o         = zero_q;
    assign alu_ctrl_o     = alu_ctrl_q;
    assign aluop_o        = aluop_q;
    assign branch_o       = branch_q;
    assign memread_o      = memread_q;
    assign memtoreg_o     = memtoreg_q;
    assign memwrite_o     = memwrite_q;
    assign alusrc_o       = alusrc_q;
    assign regwrite_o     = regwrite_q;
    assign branch_taken_o = branch_taken_q;
    assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_alu_decode_unit.sv
// Scoreboard bench for alu_decode_unit: each applied vector pushes its
// hand-computed expected registered outputs; a monitor pops one entry per
// cycle (after the edge that captured it) and compares every output.
module tb_alu_decode_unit;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic [3:0]  alu;
        logic [1:0]  aluop;
        logic [5:0]  ctrl;  // {alusrc, memtoreg, regwrite, memread, memwrite, branch}
        logic        taken;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        valid_out;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_ctrl;
    logic [1:0]  aluop;
    logic        branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic        branch_taken, illegal;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    alu_decode_unit #(.WORD(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .valid_i        (valid_in),
        .instr_i        (instr),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .imm_i          (imm),
        .valid_o        (valid_out),
        .result_o       (result),
        .zero_o         (zero),
        .alu_ctrl_o     (alu_ctrl),
        .aluop_o        (aluop),
        .branch_o       (branch),
        .memread_o      (memread),
        .memtoreg_o     (memtoreg),
        .memwrite_o     (memwrite),
        .alusrc_o       (alusrc),
        .regwrite_o     (regwrite),
        .branch_taken_o (branch_taken),
        .illegal_o      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [31:0] r, input logic z,
                                input logic [3:0] a, input logic [1:0] op,
                                input logic [5:0] c, input logic t, input logic il);
        exp_t e;
        e.valid   = v;
        e.result  = r;
        e.zero    = z;
        e.alu     = a;
        e.aluop   = op;
        e.ctrl    = c;
        e.taken   = t;
        e.illegal = il;
        return e;
    endfunction

    task automatic apply(input logic rn, input logic v, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input exp_t e);
        @(negedge clk);
        rst_n    = rn;
        valid_in = v;
        instr    = ins;
        rs1      = a;
        rs2      = b;
        imm      = im;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
        end
    endtask

    // Monitor: one expected entry per captured cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                cmp("valid_o", n_vec, {31'd0, valid_out}, {31'd0, e.valid});
                cmp("result_o", n_vec, result, e.result);
                cmp("zero_o", n_vec, {31'd0, zero}, {31'd0, e.zero});
                cmp("alu_ctrl_o", n_vec, {28'd0, alu_ctrl}, {28'd0, e.alu});
                cmp("aluop_o", n_vec, {30'd0, aluop}, {30'd0, e.aluop});
                cmp("ctrl", n_vec,
                    {26'd0, alusrc, memtoreg, regwrite, memread, memwrite, branch},
                    {26'd0, e.ctrl});
                cmp("branch_taken_o", n_vec, {31'd0, branch_taken}, {31'd0, e.taken});
                cmp("illegal_o", n_vec, {31'd0, illegal}, {31'd0, e.illegal});
                n_vec++;
            end
        end
    end

    localparam logic [5:0] C_R   = 6'b001000;
    localparam logic [5:0] C_I   = 6'b101000;
    localparam logic [5:0] C_LD  = 6'b111100;
    localparam logic [5:0] C_ST  = 6'b100010;
    localparam logic [5:0] C_BR  = 6'b000001;
    localparam logic [5:0] C_0   = 6'b000000;

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        instr    = '0;
        rs1      = '0;
        rs2      = '0;
        imm      = '0;

        // Reset with a valid instruction present: discarded, all zero.
        apply(0, 1, 32'h00000033, 5, 7, 0, mk(0, 0, 0, 4'h0, 2'b00, C_0, 0, 0));
        apply(0, 1, 32'h00000033, 5, 7, 0, mk(0, 0, 0, 4'h0, 2'b00, C_0, 0, 0));
        // Released, no valid yet: still zero.
        apply(1, 0, 32'h00000033, 5, 7, 0, mk(0, 0, 0, 4'h0, 2'b00, C_0, 0, 0));
        apply(1, 0, 32'h00000033, 5, 7, 0, mk(0, 0, 0, 4'h0, 2'b00, C_0, 0, 0));

        // R-type
        apply(1, 1, 32'h00000033, 5, 7, 32'h55,
              mk(1, 12, 0, 4'b0010, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h40000033, 9, 9, 0, mk(1, 0, 1, 4'b0110, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h00000033, 32'hFFFFFFFF, 1, 0,
              mk(1, 0, 1, 4'b0010, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h00001033, 3, 32'h21, 0, mk(1, 6, 0, 4'b0100, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h40005033, 32'h80000000, 31, 0,
              mk(1, 32'hFFFFFFFF, 0, 4'b0111, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h00004033, 32'hF0F0F0F0, 32'hFFFF0000, 0,
              mk(1, 32'h0F0FF0F0, 0, 4'b0011, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h00006033, 32'h0F, 32'hF0, 0,
              mk(1, 32'hFF, 0, 4'b0001, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h00007033, 32'hFF00FF00, 32'h0FF00FF0, 0,
              mk(1, 32'h0F000F00, 0, 4'b0000, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h00002033, 32'h80000000, 0, 0,
              mk(1, 1, 0, 4'b1000, 2'b10, C_R, 0, 0));
        apply(1, 1, 32'h00003033, 32'h80000000, 0, 0,
              mk(1, 0, 1, 4'b1001, 2'b10, C_R, 0, 0));

        // I-ALU: srai, srli, addi with b30 set (still ADD)
        apply(1, 1, 32'h40405013, 32'h80000000, 32'h99, 4,
              mk(1, 32'hF8000000, 0, 4'b0111, 2'b11, C_I, 0, 0));
        apply(1, 1, 32'h00405013, 32'h80000000, 32'h99, 4,
              mk(1, 32'h08000000, 0, 4'b0101, 2'b11, C_I, 0, 0));
        apply(1, 1, 32'h40000013, 1, 32'h99, 32'hFFFFFFFF,
              mk(1, 0, 1, 4'b0010, 2'b11, C_I, 0, 0));

        // Load / store, then a bubble that holds result/alusrc/memtoreg
        apply(1, 1, 32'h00002003, 32'h100, 32'hDEAD, 8,
              mk(1, 32'h108, 0, 4'b0010, 2'b00, C_LD, 0, 0));
        apply(1, 0, 32'h00000033, 1, 1, 1,
              mk(0, 32'h108, 0, 4'b0010, 2'b00, 6'b110000, 0, 0));
        apply(1, 1, 32'h00002023, 32'h100, 32'hDEAD, 8,
              mk(1, 32'h108, 0, 4'b0010, 2'b00, C_ST, 0, 0));

        // Branches
        apply(1, 1, 32'h00000063, 3, 3, 32'h10, mk(1, 0, 1, 4'b0110, 2'b01, C_BR, 1, 0));
        apply(1, 1, 32'h00001063, 3, 3, 32'h10, mk(1, 0, 1, 4'b0110, 2'b01, C_BR, 0, 0));
        apply(1, 1, 32'h00004063, 32'hFFFFFFFF, 1, 0,
              mk(1, 1, 0, 4'b1000, 2'b01, C_BR, 1, 0));
        apply(1, 1, 32'h00006063, 32'hFFFFFFFF, 1, 0,
              mk(1, 0, 1, 4'b1001, 2'b01, C_BR, 0, 0));
        apply(1, 1, 32'h00005063, 32'hFFFFFFFF, 1, 0,
              mk(1, 1, 0, 4'b1000, 2'b01, C_BR, 0, 0));

        // Illegal opcode (ALU falls back to ADD on rs2), then bubble
        apply(1, 1, 32'h0000007F, 5, 7, 1, mk(1, 12, 0, 4'b0010, 2'b00, C_0, 0, 1));
        apply(1, 0, 32'h00000033, 1, 1, 1, mk(0, 12, 0, 4'b0010, 2'b00, C_0, 0, 0));

        // Mid-run reset clears even the held datapath fields
        apply(0, 1, 32'h00001033, 3, 32'h21, 0, mk(0, 0, 0, 4'h0, 2'b00, C_0, 0, 0));
        apply(1, 0, 32'h00001033, 3, 32'h21, 0, mk(0, 0, 0, 4'h0, 2'b00, C_0, 0, 0));

        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_unit.md
ALU_DECODE_UNIT -- requirements
Module: alu_decode_unit

Interface
REQ-001 The block SHALL have parameter WORD, default 32, as the datapath width.
REQ-002 The block SHALL have input clk_i, width 1, as its single clock.
REQ-003 The block SHALL have input rst_ni, width 1, as reset; reset is synchronous and active-low.
REQ-004 The block SHALL have input valid_i, width 1, which qualifies the instruction and operands this cycle.
REQ-005 The block SHALL have input instr_i, width 32, as the RV32I instruction word.
REQ-006 The block SHALL have input rs1_i, width WORD, as the ALU operand A.
REQ-007 The block SHALL have input rs2_i, width WORD, as the register operand B.
REQ-008 The block SHALL have input imm_i, width WORD, as the sign-extended immediate operand B.
REQ-009 The block SHALL have output valid_o, width 1, which is the registered valid_i.
REQ-010 The block SHALL have output result_o, width WORD, as the registered ALU result.
REQ-011 The block SHALL have output zero_o, width 1, as the registered flag result==0.
REQ-012 The block SHALL have output alu_ctrl_o, width 4, as the registered ALU operation code.
REQ-013 The block SHALL have output aluop_o, width 2, as the registered main-control ALU class.
REQ-014 The block SHALL have outputs branch_o, memread_o, memtoreg_o, memwrite_o, alusrc_o and regwrite_o, each width 1, as registered control signals.
REQ-015 The block SHALL have output branch_taken_o, width 1, as the registered branch decision.
REQ-016 The block SHALL have output illegal_o, width 1, which flags an unsupported opcode.

Function
REQ-017 Main control SHALL decode instr_i[6:0] into {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop} as follows:
- 0110011 (R) -> 0,0,1,0,0,0,10
- 0010011 (I-ALU) -> 1,0,1,0,0,0,11
- 0000011 (load) -> 1,1,1,1,0,0,00
- 0100011 (store) -> 1,0,0,0,1,0,00
- 1100011 (branch) -> 0,0,0,0,0,1,01
REQ-018 Any other opcode SHALL set all control signals to 0, aluop to 00, and illegal to 1; illegal SHALL be 0 for the five listed opcodes.
REQ-019 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-020 ALU control SHALL select the ALU code from aluop, funct3 = instr_i[14:12] and b30 = instr_i[30]:
- aluop 00 -> ADD
- aluop 01: funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> SUB
- aluop 10, by funct3: 000 -> ADD (b30=0) or SUB (b30=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (b30=0) or SRA (b30=1); 110 OR; 111 AND
- aluop 11: same as aluop 10, except funct3 000 is always ADD
REQ-021 Operand B SHALL be imm_i when alusrc=1, otherwise rs2_i.
REQ-022 ADD and SUB SHALL wrap modulo 2^WORD with no overflow or carry output.
REQ-023 Shifts SHALL use B[4:0] as the shift amount; SRA SHALL replicate A[WORD-1].
REQ-024 SLT SHALL compare signed and SLTU unsigned; each SHALL output 1 or 0 zero-extended to WORD.
REQ-025 The zero flag SHALL be 1 exactly when the ALU result is all zeros.
REQ-026 When branch=1, branch taken SHALL be decided by funct3:
- 000 -> zero
- 001 -> !zero
- 100 and 110 -> !zero
- 101 and 111 -> zero
- 010 and 011 -> 0
REQ-027 When branch=0, branch taken SHALL be 0.
REQ-028 The decode and ALU SHALL be combinational, and all outputs SHALL be registered, giving one-cycle latency from valid_i to valid_o.
REQ-029 When valid_i=1, every output register SHALL load on the rising edge.
REQ-030 When valid_i=0, valid_o, regwrite_o, memwrite_o, memread_o, branch_o, branch_taken_o and illegal_o SHALL load 0, and result_o, zero_o, alu_ctrl_o, aluop_o, alusrc_o and memtoreg_o SHALL hold their values.

Reset
REQ-031 While rst_ni=0 at a rising edge, every output register SHALL load 0, including result_o, zero_o, alu_ctrl_o and aluop_o.
REQ-032 Reset SHALL take priority over valid_i, and any instruction presented in the reset cycle SHALL be discarded.
REQ-033 The first result after reset deasserts SHALL appear one cycle after the first valid_i=1 cycle.

Verification
REQ-034 Reset: hold rst_ni=0 with valid_i=1 for 2 cycles -> all outputs 0; release -> outputs stay 0 until a valid instruction.
REQ-035 R-type: ADD 0x00000033 with rs1=5, rs2=7 -> next cycle result 12, alu_ctrl 0010, regwrite 1, zero 0; SUB 0x40000033 with rs1=rs2=9 -> result 0, zero 1, alu_ctrl 0110.
REQ-036 Load/store: lw (opcode 0000011, funct3 010) with rs1=0x100, imm=8 -> result 0x108, memread 1, memtoreg 1, alusrc 1; sw with the same operands -> memwrite 1, regwrite 0.
REQ-037 Branches with rs1=rs2=3: beq -> branch_taken 1, bne -> 0; blt with rs1=-1, rs2=1 -> 1; bltu with the same operands -> 0.
REQ-038 Shifts and compares:
- srai (0010011, funct3 101, b30=1) with rs1=0x80000000, imm=4 -> 0xF8000000
- srli with the same operands -> 0x08000000
- R-type sll with rs2=0x21 -> shift by 1
REQ-039 Illegal opcode and bubble: opcode 1111111 -> illegal_o 1 and all control signals 0; then valid_i=0 -> valid_o 0, illegal_o 0, regwrite_o 0, and result_o holds its value.
